// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Optional macro MDU_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_flush,
    input  logic                  i_write_hi,
    input  logic                  i_write_lo,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_by_zero,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic            r_busy, r_done, r_dbz;
    logic [W-1:0]    r_hi, r_lo;
    logic            r_is_div;
    logic            r_neg_lo, r_neg_hi;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_acc, r_mcand;
    logic [W-1:0]    r_mplier;
    logic [W-1:0]    r_rem, r_quot, r_divisor;

    logic            w_signed_in, w_div_zero, w_start_ok, w_last;
    logic [W-1:0]    w_a_mag, w_b_mag;
    logic [2*W-1:0]  w_acc_nxt, w_prod;
    logic [W-1:0]    w_mplier_nxt;
    logic [W:0]      w_rem_sh, w_rem_diff;
    logic [W-1:0]    w_rem_nxt, w_quot_nxt, w_q_res, w_r_res;

    // Operand conditioning at launch
    assign w_signed_in = ~i_op[0];
    assign w_a_mag     = (w_signed_in && i_a[W-1]) ? -i_a : i_a;
    assign w_b_mag     = (w_signed_in && i_b[W-1]) ? -i_b : i_b;
    assign w_div_zero  = i_op[1] && (i_b == '0);
    assign w_start_ok  = i_start && !i_flush && (r_state != StRun);

    // Shift-add multiply step
    assign w_acc_nxt    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_nxt = r_mplier >> 1;
    assign w_prod       = r_neg_lo ? -w_acc_nxt : w_acc_nxt;

    // Restoring divide step; the partial remainder is always below twice the divisor,
    // so the difference's top bit doubles as the "does not fit" flag.
    assign w_rem_sh   = {r_rem, r_quot[W-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_divisor};
    assign w_rem_nxt  = w_rem_diff[W] ? w_rem_sh[W-1:0] : w_rem_diff[W-1:0];
    assign w_quot_nxt = {r_quot[W-2:0], ~w_rem_diff[W]};
    assign w_q_res    = r_neg_lo ? -w_quot_nxt : w_quot_nxt;
    assign w_r_res    = r_neg_hi ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_last = (r_cnt == CW'(1));
`ifdef MDU_EARLY_OUT_EN
        if (!r_is_div && (w_mplier_nxt == '0)) begin
            w_last = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle, StDone: begin
                if (w_start_ok) begin
                    w_state_nxt = w_div_zero ? StDone : StRun;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StRun: begin
                if (i_flush) begin
                    w_state_nxt = StIdle;
                end else if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == StRun);
            r_done  <= (w_state_nxt == StDone);
            // DONE reached without a RUN phase only happens for a zero divisor
            r_dbz   <= (w_state_nxt == StDone) && (r_state != StRun);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else begin
            if (r_state != StRun) begin
                if (i_write_hi) r_hi <= i_write_data;
                if (i_write_lo) r_lo <= i_write_data;
            end
            if (w_start_ok) begin
                r_is_div  <= i_op[1];
                r_neg_lo  <= w_signed_in & (i_a[W-1] ^ i_b[W-1]);
                r_neg_hi  <= w_signed_in & i_a[W-1];
                r_cnt     <= CW'(W);
                r_acc     <= '0;
                r_mcand   <= {{W{1'b0}}, w_a_mag};
                r_mplier  <= w_b_mag;
                r_rem     <= '0;
                r_quot    <= w_a_mag;
                r_divisor <= w_b_mag;
            end else if ((r_state == StRun) && !i_flush) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_is_div) begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                end else begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                end
                if (w_last) begin
                    if (r_is_div) begin
                        r_lo <= w_q_res;
                        r_hi <= w_r_res;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: spec vector table, corner sequences, random ops vs model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, flush, write_hi, write_lo;
    logic [1:0]  op;
    logic [31:0] a, b, write_data;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .i_flush(flush), .i_write_hi(write_hi), .i_write_lo(write_lo),
        .i_write_data(write_data), .o_busy(busy), .o_done(done), .o_div_by_zero(dbz),
        .o_hi(hi), .o_lo(lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural reference: plain 64-bit arithmetic, truncating signed division.
    task automatic model_op(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                            output logic exp_dbz, output int exp_cycles);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        logic [31:0] mag;
        sa = mop[0] ? {32'b0, ma} : {{32{ma[31]}}, ma};
        sb = mop[0] ? {32'b0, mb} : {{32{mb[31]}}, mb};
        exp_dbz = 1'b0;
        exp_cycles = 32;
        if (mop[1]) begin
            if (mb == 32'd0) begin
                exp_dbz = 1'b1;
                exp_cycles = 0;
            end else begin
                sq = sa / sb;
                sr = sa % sb;
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
        end else begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
`ifdef MDU_EARLY_OUT_EN
            mag = (sb < 0) ? -mb : mb;
            exp_cycles = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) exp_cycles = i + 1;
`else
            mag = mb;
`endif
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] rop, input logic [31:0] ra,
                          input logic [31:0] rb);
        int n, exp_n, early_done;
        logic exp_dbz;
        model_op(rop, ra, rb, exp_dbz, exp_n);
        op = rop; a = ra; b = rb; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        early_done = 0;
        while (busy && n < 100) begin
            if (done) early_done++;
            n++;
            step();
        end
        chk({name, " busy cycles"}, 64'(n), 64'(exp_n));
        chk({name, " done during busy"}, 64'(early_done), 64'd0);
        chk({name, " done"}, {63'd0, done}, 64'd1);
        chk({name, " divbyzero"}, {63'd0, dbz}, {63'd0, exp_dbz});
        chk({name, " hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({name, " lo"}, {32'd0, lo}, {32'd0, m_lo});
        step();
        chk({name, " done pulse ends"}, {63'd0, done}, 64'd0);
    endtask

    vec_t tbl[$];

    initial begin
        int n, dones, dbz_seen;
        logic d;
        int c;

        tbl.push_back('{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB});
        tbl.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        tbl.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
        tbl.push_back('{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        tbl.push_back('{2'b11, 32'd7,        32'd2,        32'd1,        32'd3});
        tbl.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000});
        tbl.push_back('{2'b11, 32'd100,      32'd7,        32'd2,        32'd14});
        tbl.push_back('{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
        tbl.push_back('{2'b01, 32'd5,        32'd3,        32'd0,        32'd15});

        reset = 1'b1; start = 1'b0; flush = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
        op = 2'b00; a = '0; b = '0; write_data = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset outputs", {29'd0, busy, done, dbz, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);

        foreach (tbl[i]) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d spec hi", i), {32'd0, hi}, {32'd0, tbl[i].hi});
            chk($sformatf("tbl%0d spec lo", i), {32'd0, lo}, {32'd0, tbl[i].lo});
        end

        // MTHI/MTLO then divide by zero: HI/LO must survive
        write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h1234;
        step();
        write_hi = 1'b0; write_lo = 1'b0;
        m_hi = 32'h1234; m_lo = 32'h1234;
        chk("mthi", {32'd0, hi}, 64'h1234);
        chk("mtlo", {32'd0, lo}, 64'h1234);
        run_op("div0", 2'b10, 32'd5, 32'd0);

        // Write together with Start lands first, result overwrites it later
        write_lo = 1'b1; write_data = 32'hAAAA;
        run_op("start+mtlo", 2'b01, 32'd2, 32'd3);
        write_lo = 1'b0;

        // Start and MTHI while busy are ignored; one Done only
        model_op(2'b01, 32'd3, 32'h80000005, d, c);
        op = 2'b01; a = 32'd3; b = 32'h80000005; start = 1'b1;
        step();
        start = 1'b0;
        n = 0; dones = 0; dbz_seen = 0;
        while (busy && n < 100) begin
            start = (n == 3); write_hi = (n == 3);
            op = 2'b11; a = 32'd9; b = 32'd0; write_data = 32'hDEAD;
            n++;
            step();
        end
        start = 1'b0; write_hi = 1'b0;
        chk("busy-restart cycles", 64'(n), 64'(c));
        repeat (5) begin
            if (done) dones++;
            if (dbz) dbz_seen++;
            step();
        end
        chk("busy-restart done count", 64'(dones), 64'd1);
        chk("busy-restart no dbz", 64'(dbz_seen), 64'd0);
        chk("busy-restart hi", {32'd0, hi}, {32'd0, m_hi});
        chk("busy-restart lo", {32'd0, lo}, {32'd0, m_lo});

        // Flush on RUN cycle 10
        write_hi = 1'b1; write_data = 32'h55;
        step();
        write_hi = 1'b0; write_lo = 1'b1; write_data = 32'h66;
        step();
        write_lo = 1'b0;
        m_hi = 32'h55; m_lo = 32'h66;
        op = 2'b01; a = 32'd3; b = 32'h80000005; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("flush pre busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush busy", {63'd0, busy}, 64'd0);
        dones = 0;
        repeat (40) begin
            if (done || busy) dones++;
            step();
        end
        chk("flush no done", 64'(dones), 64'd0);
        chk("flush hi", {32'd0, hi}, 64'h55);
        chk("flush lo", {32'd0, lo}, 64'h66);

        // Start in the same cycle as Flush is ignored
        op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("start+flush busy", {63'd0, busy}, 64'd0);
        step();
        chk("start+flush done", {63'd0, done}, 64'd0);

        // Reset on RUN cycle 5
        write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h77;
        step();
        write_hi = 1'b0; write_lo = 1'b0;
        op = 2'b01; a = 32'd3; b = 32'h80000005; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("midrun reset flags", {61'd0, busy, done, dbz}, 64'd0);
        chk("midrun reset hilo", {hi, lo}, 64'd0);
        dones = 0;
        repeat (40) begin
            if (done) dones++;
            step();
        end
        chk("midrun reset no done", 64'(dones), 64'd0);

        // Randomized ops against the reference model
        for (int k = 0; k < 60; k++) begin
            logic [1:0] rop;
            logic [31:0] ra, rb;
            int sel;
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                3: rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d op%0d a=%h b=%h", k, rop, ra, rb), rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
